// File: rtl/dc_ft_pkg.sv
// Shared definitions for the coded-DC fault-tolerance error locator:
// FSM state encoding, default sizes and the location-width helper.
package dc_ft_pkg;

  localparam int DEFAULT_OUTWIDTH = 19;
  localparam int DEFAULT_NUM_POS  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } loc_state_e;

  function automatic int loc_width(input int num_pos);
    return (num_pos > 1) ? $clog2(num_pos) : 1;
  endfunction

endpackage

// File: rtl/locate_error_from_deltas_seq_udiv.sv
// Sequential restoring unsigned divider: one quotient bit per clock, MSB first.
// The first step is taken on the start edge, so done pulses after W edges.
module seq_udiv #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic [W-1:0] r
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  quo_r;
  logic [W-1:0]  rem_r;
  logic [W-1:0]  dvs_r;
  logic [CW-1:0] cnt_r;
  logic          busy_r;
  logic          done_r;

  logic          load_s;
  logic [W-1:0]  src_quo_s;
  logic [W-1:0]  src_rem_s;
  logic [W-1:0]  src_dvs_s;
  logic [W:0]    trial_s;
  logic [W:0]    diff_s;
  logic [W-1:0]  rem_next_s;
  logic [W-1:0]  quo_next_s;

  assign load_s = start && !busy_r;

  // One restoring step; the trial value carries an extra bit so it never overflows.
  always_comb begin
    src_quo_s  = load_s ? dividend : quo_r;
    src_rem_s  = load_s ? {W{1'b0}} : rem_r;
    src_dvs_s  = load_s ? divisor : dvs_r;
    trial_s    = {src_rem_s, src_quo_s[W-1]};
    diff_s     = trial_s - {1'b0, src_dvs_s};
    rem_next_s = trial_s[W-1:0];
    quo_next_s = {src_quo_s[W-2:0], 1'b0};
    if (trial_s >= {1'b0, src_dvs_s}) begin
      rem_next_s = diff_s[W-1:0];
      quo_next_s = {src_quo_s[W-2:0], 1'b1};
    end else begin
      rem_next_s = trial_s[W-1:0];
      quo_next_s = {src_quo_s[W-2:0], 1'b0};
    end
  end

  // Divider datapath, iteration counter and handshake flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      quo_r  <= {W{1'b0}};
      rem_r  <= {W{1'b0}};
      dvs_r  <= {W{1'b0}};
      cnt_r  <= {CW{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (load_s) begin
      quo_r  <= quo_next_s;
      rem_r  <= rem_next_s;
      dvs_r  <= divisor;
      cnt_r  <= CW'(1);
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      quo_r <= quo_next_s;
      rem_r <= rem_next_s;
      cnt_r <= cnt_r + CW'(1);
      if (cnt_r == CW'(W - 1)) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        busy_r <= 1'b1;
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign q    = quo_r;
  assign r    = rem_r;

endmodule

// File: rtl/locate_error_from_deltas.sv
// Locates a single corrupted check column from the delta1/delta2 sums by
// dividing delta2 by delta1; anything other than one clean hit is uncorrectable.
module locate_error_from_deltas
  import dc_ft_pkg::*;
#(
  parameter  int OUTWIDTH = DEFAULT_OUTWIDTH,
  parameter  int NUM_POS  = DEFAULT_NUM_POS,
  localparam int LOCW     = loc_width(NUM_POS)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [OUTWIDTH-1:0] delta1_sumup_i,
  input  logic [OUTWIDTH-1:0] delta2_sumup_i,
  input  logic                sumup_en_i,
  output logic                busy_o,
  output logic                loc_valid_o,
  output logic                err_found_o,
  output logic                err_uncorr_o,
  output logic [LOCW-1:0]     err_loc_o,
  output logic [OUTWIDTH-1:0] err_mag_o,
  output logic                overrun_o
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_DIV  = DIV;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]          state_r;
  logic [1:0]          state_next_s;
  logic [OUTWIDTH-1:0] d1_r;
  logic [OUTWIDTH-1:0] d2_r;
  logic                zero_r;
  logic                busy_r;
  logic                valid_r;
  logic                found_r;
  logic                uncorr_r;
  logic [LOCW-1:0]     loc_r;
  logic [OUTWIDTH-1:0] mag_r;
  logic                overrun_r;

  logic                accept_s;
  logic                div_start_s;
  logic                div_busy_s;
  logic                div_done_s;
  logic [OUTWIDTH-1:0] div_q_s;
  logic [OUTWIDTH-1:0] div_r_s;
  logic [OUTWIDTH-1:0] q_m1_s;
  logic                found_s;
  logic                uncorr_s;
  logic [LOCW-1:0]     loc_s;
  logic [OUTWIDTH-1:0] mag_s;

  assign accept_s    = (state_r == S_IDLE) && sumup_en_i;
  assign div_start_s = accept_s && (delta1_sumup_i != {OUTWIDTH{1'b0}}) && !div_busy_s;
  assign q_m1_s      = div_q_s - OUTWIDTH'(1);

  seq_udiv #(
    .W(OUTWIDTH)
  ) u_div (
    .clk      (clk),
    .rstn     (rstn),
    .start    (div_start_s),
    .dividend (delta2_sumup_i),
    .divisor  (delta1_sumup_i),
    .busy     (div_busy_s),
    .done     (div_done_s),
    .q        (div_q_s),
    .r        (div_r_s)
  );

  // Next-state logic; a zero delta1 skips the divider and spends one cycle in DIV.
  always_comb begin
    state_next_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (sumup_en_i) state_next_s = S_DIV;
        else            state_next_s = S_IDLE;
      end
      S_DIV: begin
        if (zero_r || div_done_s) state_next_s = S_DONE;
        else                      state_next_s = S_DIV;
      end
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Classifier: exact quotient in 1..NUM_POS is a single error at column q-1.
  always_comb begin
    found_s  = 1'b0;
    uncorr_s = 1'b0;
    loc_s    = {LOCW{1'b0}};
    mag_s    = {OUTWIDTH{1'b0}};
    if (zero_r) begin
      uncorr_s = (d2_r != {OUTWIDTH{1'b0}});
    end else if ((div_r_s == {OUTWIDTH{1'b0}}) && (div_q_s >= OUTWIDTH'(1)) &&
                 (div_q_s <= OUTWIDTH'(NUM_POS))) begin
      found_s = 1'b1;
      loc_s   = q_m1_s[LOCW-1:0];
      mag_s   = d1_r;
    end else begin
      uncorr_s = 1'b1;
    end
  end

  // FSM, operand capture, status flags and result registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= S_IDLE;
      d1_r      <= {OUTWIDTH{1'b0}};
      d2_r      <= {OUTWIDTH{1'b0}};
      zero_r    <= 1'b0;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      found_r   <= 1'b0;
      uncorr_r  <= 1'b0;
      loc_r     <= {LOCW{1'b0}};
      mag_r     <= {OUTWIDTH{1'b0}};
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      busy_r    <= (state_next_s != S_IDLE);
      valid_r   <= (state_next_s == S_DONE);
      overrun_r <= sumup_en_i && (state_r != S_IDLE);
      if (accept_s) begin
        d1_r   <= delta1_sumup_i;
        d2_r   <= delta2_sumup_i;
        zero_r <= (delta1_sumup_i == {OUTWIDTH{1'b0}});
      end
      if ((state_r == S_DIV) && (state_next_s == S_DONE)) begin
        found_r  <= found_s;
        uncorr_r <= uncorr_s;
        loc_r    <= loc_s;
        mag_r    <= mag_s;
      end
    end
  end

  assign busy_o       = busy_r;
  assign loc_valid_o  = valid_r;
  assign err_found_o  = found_r;
  assign err_uncorr_o = uncorr_r;
  assign err_loc_o    = loc_r;
  assign err_mag_o    = mag_r;
  assign overrun_o    = overrun_r;

endmodule
